// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle controller.
//   - state codes (4-bit, codes 12..15 unused)
//   - opcode constants (Instr[31:26])
//   - ALUSrcB / ALUOp / PCSource encodings
//   - is_mem_state(): states that use the memory wait counter
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StRtExe   = 4'd6,
        StRtWb    = 4'd7,
        StBeq     = 4'd8,
        StAddiExe = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    function automatic logic is_mem_state(input state_e s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: opcode input and control outputs of the multicycle controller.
//   master : the controller (drives control signals and State, reads Op)
//   slave  : the datapath (drives Op, reads control signals)
interface multicycle_ctrl_if;
    logic [5:0] Op;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic [3:0] State;

    modport master (
        input  Op,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, State
    );

    modport slave (
        output Op,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, State
    );
endinterface

// File: rtl/mc_wait_cnt.sv
// mc_wait_cnt: down-counter that holds a memory state for a fixed number of cycles.
//   clk_i, rst_ni : clock, async active-low reset (counter resets to ResetVal)
//   load_i        : load load_val_i this cycle (takes priority over decrement)
//   load_val_i    : value to load
//   zero_o        : counter currently equals zero
// The counter decrements every cycle until it reaches zero and then holds.
module mc_wait_cnt #(
    parameter int unsigned Width    = 4,
    parameter logic [3:0]  ResetVal = 4'd0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= Width'(ResetVal);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-FSM control unit for a multicycle MIPS-subset datapath
// (lw, sw, R-type, beq, addi and optionally j).
//   Clk   : system clock, rising edge
//   Rst_n : async active-low reset; forces FETCH and clears all write strobes
//   mc    : multicycle_ctrl_if.master -- Op in, datapath controls and State out
// Parameter MEM_LAT (1..15): cycles spent in each of FETCH / MEMRD / MEMWR.
// Macro MULTICYCLE_CTRL_JUMP_EN: when defined, Op 000010 decodes to the JUMP
// state; otherwise it is treated as an illegal opcode.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic               Clk,
    input  logic               Rst_n,
    multicycle_ctrl_if.master  mc
);

    localparam logic [3:0] WaitInit = 4'(MEM_LAT - 1);

    state_e state_q, state_d;
    logic   wait_zero;
    logic   wait_load;

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;

    // Reload the counter whenever a memory state is entered from a different state.
    assign wait_load = (state_d != state_q) && is_mem_state(state_d);

    mc_wait_cnt #(
        .Width    (4),
        .ResetVal (WaitInit)
    ) u_wait_cnt (
        .clk_i      (Clk),
        .rst_ni     (Rst_n),
        .load_i     (wait_load),
        .load_val_i (WaitInit),
        .zero_o     (wait_zero)
    );

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: begin
                if (wait_zero) state_d = StDecode;
            end
            StDecode: begin
                case (mc.Op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StRtExe;
                    OpBeq:      state_d = StBeq;
                    OpAddi:     state_d = StAddiExe;
`ifdef MULTICYCLE_CTRL_JUMP_EN
                    OpJ:        state_d = StJump;
`endif
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                if (mc.Op == OpLw) begin
                    state_d = StMemRd;
                end else if (mc.Op == OpSw) begin
                    state_d = StMemWr;
                end else begin
                    state_d = StFetch;
                end
            end
            StMemRd: begin
                if (wait_zero) state_d = StMemWb;
            end
            StMemWr: begin
                if (wait_zero) state_d = StFetch;
            end
            StRtExe:   state_d = StRtWb;
            StAddiExe: state_d = StAddiWb;
            StMemWb, StRtWb, StBeq, StAddiWb: state_d = StFetch;
            // Covers JUMP (returns to FETCH) and, when the jump is disabled or
            // the code is unused, recovers straight to FETCH.
            default:   state_d = StFetch;
        endcase
    end

    // Output decode from registered state and wait flag only.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SrcBReg;
        alu_op        = AluAdd;
        pc_source     = PcAlu;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SrcBFour;
                // IR and PC only update once the memory word is valid.
                ir_write  = wait_zero;
                pc_write  = wait_zero;
            end
            StDecode: begin
                alu_src_b = SrcBImmSh;
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            StRtExe: begin
                alu_src_a = 1'b1;
                alu_op    = AluFunct;
            end
            StRtWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StBeq: begin
                alu_src_a     = 1'b1;
                alu_op        = AluSub;
                pc_write_cond = 1'b1;
                pc_source     = PcAluOut;
            end
            StAddiExe: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
            end
            StAddiWb: begin
                reg_write = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_JUMP_EN
            StJump: begin
                pc_write  = 1'b1;
                pc_source = PcJump;
            end
`endif
            default: ;
        endcase
    end

    // Write strobes are masked by reset so that FETCH's last-cycle strobes
    // cannot fire while reset is held.
    assign mc.PCWrite     = pc_write & Rst_n;
    assign mc.PCWriteCond = pc_write_cond & Rst_n;
    assign mc.MemWrite    = mem_write & Rst_n;
    assign mc.IRWrite     = ir_write & Rst_n;
    assign mc.RegWrite    = reg_write & Rst_n;
    assign mc.IorD        = iord;
    assign mc.MemRead     = mem_read;
    assign mc.MemtoReg    = mem_to_reg;
    assign mc.RegDst      = reg_dst;
    assign mc.ALUSrcA     = alu_src_a;
    assign mc.ALUSrcB     = alu_src_b;
    assign mc.ALUOp       = alu_op;
    assign mc.PCSource    = pc_source;
    assign mc.State       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench for multicycle_ctrl with MEM_LAT=1 and MEM_LAT=3.
module tb_multicycle_ctrl;
    import mc_pkg::*;

    logic Clk;
    logic Rst_n;
    int   vectors;
    int   miscompares;

    multicycle_ctrl_if if1 ();
    multicycle_ctrl_if if3 ();

    multicycle_ctrl #(.MEM_LAT(1)) u_lat1 (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .mc    (if1)
    );

    multicycle_ctrl #(.MEM_LAT(3)) u_lat3 (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .mc    (if3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Reset released on a falling edge; returns 1 time unit later, before the
    // first rising edge (which executes FETCH's first cycle).
    task automatic reset_dut();
        Rst_n = 1'b0;
        #7;
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Rst_n       = 1'b0;
        if1.Op      = OpLw;
        if3.Op      = OpRtype;

        // Reset state while reset is held (MEM_LAT=1: FETCH strobes masked).
        #12;
        check("rst_state", 8'(if1.State), 8'd0);
        check("rst_pcwrite", 8'(if1.PCWrite), 8'd0);
        check("rst_irwrite", 8'(if1.IRWrite), 8'd0);
        check("rst_memwrite", 8'(if1.MemWrite), 8'd0);
        check("rst_memread", 8'(if1.MemRead), 8'd1);

        // lw, MEM_LAT=1: 0,1,2,3,4,0.
        reset_dut();
        check("lw_s0", 8'(if1.State), 8'd0);
        check("lw_fetch_ir", 8'(if1.IRWrite), 8'd1);
        check("lw_fetch_pc", 8'(if1.PCWrite), 8'd1);
        check("lw_fetch_srcb", 8'(if1.ALUSrcB), 8'd1);
        step();
        check("lw_s1", 8'(if1.State), 8'd1);
        check("lw_dec_rw", 8'(if1.RegWrite), 8'd0);
        step();
        check("lw_s2", 8'(if1.State), 8'd2);
        check("lw_adr_srcb", 8'(if1.ALUSrcB), 8'd2);
        check("lw_adr_srca", 8'(if1.ALUSrcA), 8'd1);
        step();
        check("lw_s3", 8'(if1.State), 8'd3);
        check("lw_rd_iord", 8'(if1.IorD), 8'd1);
        check("lw_rd_mr", 8'(if1.MemRead), 8'd1);
        check("lw_rd_rw", 8'(if1.RegWrite), 8'd0);
        step();
        check("lw_s4", 8'(if1.State), 8'd4);
        check("lw_wb_rw", 8'(if1.RegWrite), 8'd1);
        check("lw_wb_m2r", 8'(if1.MemtoReg), 8'd1);
        step();
        check("lw_s5", 8'(if1.State), 8'd0);
        check("lw_end_rw", 8'(if1.RegWrite), 8'd0);

        // R-type, MEM_LAT=3: FETCH x3 (strobes in 3rd), DECODE, RTEXE, RTWB.
        if3.Op = OpRtype;
        reset_dut();
        check("rt_f1_state", 8'(if3.State), 8'd0);
        check("rt_f1_ir", 8'(if3.IRWrite), 8'd0);
        check("rt_f1_pc", 8'(if3.PCWrite), 8'd0);
        step();
        check("rt_f2_state", 8'(if3.State), 8'd0);
        check("rt_f2_ir", 8'(if3.IRWrite), 8'd0);
        step();
        check("rt_f3_state", 8'(if3.State), 8'd0);
        check("rt_f3_ir", 8'(if3.IRWrite), 8'd1);
        check("rt_f3_pc", 8'(if3.PCWrite), 8'd1);
        step();
        check("rt_dec", 8'(if3.State), 8'd1);
        step();
        check("rt_exe", 8'(if3.State), 8'd6);
        check("rt_exe_aluop", 8'(if3.ALUOp), 8'd2);
        check("rt_exe_srcb", 8'(if3.ALUSrcB), 8'd0);
        step();
        check("rt_wb", 8'(if3.State), 8'd7);
        check("rt_wb_rw", 8'(if3.RegWrite), 8'd1);
        check("rt_wb_rd", 8'(if3.RegDst), 8'd1);
        step();
        check("rt_done", 8'(if3.State), 8'd0);

        // beq, MEM_LAT=1.
        if1.Op = OpBeq;
        reset_dut();
        step();
        check("beq_dec", 8'(if1.State), 8'd1);
        check("beq_dec_srcb", 8'(if1.ALUSrcB), 8'd3);
        step();
        check("beq_state", 8'(if1.State), 8'd8);
        check("beq_pwc", 8'(if1.PCWriteCond), 8'd1);
        check("beq_srcb", 8'(if1.ALUSrcB), 8'd0);
        check("beq_aluop", 8'(if1.ALUOp), 8'd1);
        check("beq_pcsrc", 8'(if1.PCSource), 8'd1);
        step();
        check("beq_done", 8'(if1.State), 8'd0);

        // Illegal opcode: 0,1,0 and no write strobe in DECODE.
        if1.Op = 6'b111111;
        reset_dut();
        step();
        check("ill_dec", 8'(if1.State), 8'd1);
        check("ill_dec_pw", 8'(if1.PCWrite), 8'd0);
        check("ill_dec_rw", 8'(if1.RegWrite), 8'd0);
        check("ill_dec_mw", 8'(if1.MemWrite), 8'd0);
        step();
        check("ill_back", 8'(if1.State), 8'd0);

        // Jump opcode.
        if1.Op = OpJ;
        reset_dut();
        step();
        check("j_dec", 8'(if1.State), 8'd1);
        step();
`ifdef MULTICYCLE_CTRL_JUMP_EN
        check("j_state", 8'(if1.State), 8'd11);
        check("j_pw", 8'(if1.PCWrite), 8'd1);
        check("j_pcsrc", 8'(if1.PCSource), 8'd2);
        step();
        check("j_done", 8'(if1.State), 8'd0);
`else
        check("j_illegal", 8'(if1.State), 8'd0);
        check("j_pcsrc", 8'(if1.PCSource), 8'd0);
`endif

        // sw, MEM_LAT=1: 0,1,2,5,0.
        if1.Op = OpSw;
        reset_dut();
        step();
        step();
        check("sw_adr", 8'(if1.State), 8'd2);
        step();
        check("sw_wr", 8'(if1.State), 8'd5);
        check("sw_wr_mw", 8'(if1.MemWrite), 8'd1);
        check("sw_wr_iord", 8'(if1.IorD), 8'd1);
        step();
        check("sw_done", 8'(if1.State), 8'd0);
        check("sw_done_mw", 8'(if1.MemWrite), 8'd0);

        // sw, MEM_LAT=3, reset asserted in the 2nd MEMWR cycle.
        if3.Op = OpSw;
        reset_dut();
        step();
        step();
        step();
        check("sw3_dec", 8'(if3.State), 8'd1);
        step();
        check("sw3_adr", 8'(if3.State), 8'd2);
        step();
        check("sw3_wr1", 8'(if3.State), 8'd5);
        check("sw3_wr1_mw", 8'(if3.MemWrite), 8'd1);
        step();
        check("sw3_wr2", 8'(if3.State), 8'd5);
        check("sw3_wr2_mw", 8'(if3.MemWrite), 8'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        check("sw3_rst_mw", 8'(if3.MemWrite), 8'd0);
        check("sw3_rst_state", 8'(if3.State), 8'd0);
        // Counter reloaded: FETCH takes three cycles again after release.
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("sw3_post_ir", 8'(if3.IRWrite), 8'd0);
        step();
        step();
        check("sw3_post_ir3", 8'(if3.IRWrite), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
